// File: rtl/wb_trace_fifo.sv
// Commit-trace buffer: captures register-file writes from the core's writeback
// debug bus into a first-word-fall-through FIFO and keeps commit/drop statistics.
module wb_trace_fifo #(
   parameter int unsigned DEPTH   = 16,
   parameter bit          SKIP_R0 = 1'b1
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       trace_en,
   input  logic                       clr_stats,
   input  logic [31:0]                debug_wb_pc,
   input  logic                       debug_wb_rf_wen,
   input  logic [4:0]                 debug_wb_rf_addr,
   input  logic [31:0]                debug_wb_rf_wdata,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_pc,
   output logic [4:0]                 out_addr,
   output logic [31:0]                out_data,
   output logic [$clog2(DEPTH):0]     occupancy,
   output logic [31:0]                commit_cnt,
   output logic [15:0]                drop_cnt,
   output logic                       overflow
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned OccW = PtrW + 1;
   localparam logic [OccW-1:0] OccFull = OccW'(DEPTH);

   // Record layout: {pc[31:0], addr[4:0], data[31:0]}
   logic [68:0]     mem [DEPTH];
   logic [68:0]     head;
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [OccW-1:0] occ_q;
   logic            cap, pop, push, drop, full;

   assign full      = (occ_q == OccFull);
   assign out_valid = (occ_q != '0);
   assign occupancy = occ_q;

   assign cap  = trace_en & debug_wb_rf_wen & ~(SKIP_R0 & (debug_wb_rf_addr == 5'd0));
   assign pop  = out_valid & out_ready;
   // A same-cycle pop frees the slot the new record needs.
   assign push = cap & (~full | pop);
   assign drop = cap & full & ~pop;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= {debug_wb_pc, debug_wb_rf_addr, debug_wb_rf_wdata};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         if (push && !pop)      occ_q <= occ_q + OccW'(1);
         else if (pop && !push) occ_q <= occ_q - OccW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         commit_cnt <= '0;
         drop_cnt   <= '0;
         overflow   <= 1'b0;
      end else if (clr_stats) begin
         commit_cnt <= '0;
         drop_cnt   <= '0;
         overflow   <= 1'b0;
      end else begin
         if (cap) commit_cnt <= commit_cnt + 32'd1;
         if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
         end
      end
   end

   // Payload is forced to zero while empty so nothing stale or uninitialised leaks out.
   assign head     = mem[rd_ptr_q];
   assign out_pc   = out_valid ? head[68:37] : 32'd0;
   assign out_addr = out_valid ? head[36:32] : 5'd0;
   assign out_data = out_valid ? head[31:0]  : 32'd0;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Self-checking bench for wb_trace_fifo: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_wb_trace_fifo;

   localparam int unsigned DEPTH   = 16;
   localparam bit          SKIP_R0 = 1'b1;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        trace_en = 1'b0, clr_stats = 1'b0;
   logic [31:0] debug_wb_pc = '0, debug_wb_rf_wdata = '0;
   logic        debug_wb_rf_wen = 1'b0;
   logic [4:0]  debug_wb_rf_addr = '0;
   logic        out_valid, out_ready = 1'b0;
   logic [31:0] out_pc, out_data, commit_cnt;
   logic [4:0]  out_addr;
   logic [4:0]  occupancy;
   logic [15:0] drop_cnt;
   logic        overflow;

   wb_trace_fifo #(.DEPTH(DEPTH), .SKIP_R0(SKIP_R0)) dut (
      .clk(clk), .reset_n(reset_n), .trace_en(trace_en), .clr_stats(clr_stats),
      .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
      .debug_wb_rf_addr(debug_wb_rf_addr), .debug_wb_rf_wdata(debug_wb_rf_wdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_addr(out_addr),
      .out_data(out_data), .occupancy(occupancy), .commit_cnt(commit_cnt),
      .drop_cnt(drop_cnt), .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [4:0]  addr;
      logic [31:0] data;
   } rec_t;

   rec_t        mq[$];
   logic [31:0] m_commit;
   int          m_drop;
   bit          m_ov;
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic en, input logic wen, input logic [4:0] addr,
                        input logic [31:0] pc, input logic [31:0] data,
                        input logic ready, input logic clr);
      trace_en = en; debug_wb_rf_wen = wen; debug_wb_rf_addr = addr;
      debug_wb_pc = pc; debug_wb_rf_wdata = data; out_ready = ready; clr_stats = clr;
   endtask

   task automatic model_clear();
      mq.delete();
      m_commit = 0; m_drop = 0; m_ov = 0;
   endtask

   task automatic check_model();
      check("valid", 64'(out_valid), 64'(mq.size() != 0));
      check("occupancy", 64'(occupancy), 64'(mq.size()));
      check("commit_cnt", 64'(commit_cnt), 64'(m_commit));
      check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      check("overflow", 64'(overflow), 64'(m_ov));
      if (mq.size() != 0) begin
         check("out_pc", 64'(out_pc), 64'(mq[0].pc));
         check("out_addr", 64'(out_addr), 64'(mq[0].addr));
         check("out_data", 64'(out_data), 64'(mq[0].data));
      end
   endtask

   // Apply one clock with the currently driven inputs, advancing the model alongside.
   task automatic step();
      bit   cap, pop, drop;
      int   sz;
      rec_t r;
      sz   = mq.size();
      cap  = trace_en && debug_wb_rf_wen && !(SKIP_R0 && debug_wb_rf_addr == 0);
      pop  = (sz != 0) && out_ready;
      drop = cap && (sz == DEPTH) && !pop;
      if (pop) void'(mq.pop_front());
      if (cap && !drop) begin
         r.pc = debug_wb_pc; r.addr = debug_wb_rf_addr; r.data = debug_wb_rf_wdata;
         mq.push_back(r);
      end
      if (clr_stats) begin
         m_commit = 0; m_drop = 0; m_ov = 0;
      end else begin
         if (cap) m_commit = m_commit + 1;
         if (drop) begin
            m_ov = 1;
            if (m_drop < 65535) m_drop++;
         end
      end
      @(posedge clk);
      #1;
      check_model();
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 0, 0);
      reset_n = 1'b0;
      model_clear();
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   logic [31:0] saved_pc;
   int          occ_seq[5] = '{2, 2, 1, 1, 0};
   int          rdy_seq[5] = '{1, 0, 1, 0, 1};

   initial begin
      // Reset state
      do_reset();
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_occ", 64'(occupancy), 64'd0);
      check("rst_commit", 64'(commit_cnt), 64'd0);
      check("rst_drop", 64'(drop_cnt), 64'd0);
      check("rst_ov", 64'(overflow), 64'd0);
      check("rst_payload", {27'd0, out_addr, out_pc}, 64'd0);
      check("rst_data", 64'(out_data), 64'd0);

      // Single capture, one-cycle latency
      drive(1, 1, 5, 32'h0040_0000, 32'h1234, 0, 0);
      step();
      check("first_valid", 64'(out_valid), 64'd1);
      check("first_pc", 64'(out_pc), 64'h0040_0000);
      check("first_addr", 64'(out_addr), 64'd5);
      check("first_data", 64'(out_data), 64'h1234);
      check("first_occ", 64'(occupancy), 64'd1);
      check("first_commit", 64'(commit_cnt), 64'd1);

      // Writes to x0 are skipped
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 0, 32'h200 + 32'(i), 32'hDEAD, 0, 0);
         step();
      end
      check("r0_occ", 64'(occupancy), 64'd0);
      check("r0_commit", 64'(commit_cnt), 64'd0);
      check("r0_valid", 64'(out_valid), 64'd0);

      // Overfill: 20 captures into 16 entries
      do_reset();
      for (int i = 0; i < 20; i++) begin
         drive(1, 1, 5'(i + 1), 32'h100 + 32'(4 * i), $urandom, 0, 0);
         step();
      end
      check("ovf_occ", 64'(occupancy), 64'd16);
      check("ovf_drop", 64'(drop_cnt), 64'd4);
      check("ovf_flag", 64'(overflow), 64'd1);
      check("ovf_commit", 64'(commit_cnt), 64'd20);
      for (int i = 0; i < 16; i++) begin
         check("drain_pc", 64'(out_pc), 64'(32'h100 + 32'(4 * i)));
         drive(0, 0, 0, 0, 0, 1, 0);
         step();
      end
      check("drain_empty", 64'(out_valid), 64'd0);

      // Full plus simultaneous pop accepts the new record at the tail
      for (int i = 0; i < 16; i++) begin
         drive(1, 1, 5'd7, 32'h300 + 32'(4 * i), 32'(i), 0, 0);
         step();
      end
      drive(1, 1, 5'd9, 32'h999, 32'hCAFE, 1, 0);
      step();
      check("fullpop_occ", 64'(occupancy), 64'd16);
      check("fullpop_drop", 64'(drop_cnt), 64'd4);
      check("fullpop_tail", 64'(mq[15].pc), 64'h999);

      // Drop and clear in the same cycle: clear wins
      drive(1, 1, 5'd3, 32'h500, 32'h1, 0, 1);
      step();
      check("clr_drop", 64'(drop_cnt), 64'd0);
      check("clr_ov", 64'(overflow), 64'd0);
      check("clr_commit", 64'(commit_cnt), 64'd0);
      check("clr_occ", 64'(occupancy), 64'd16);
      for (int i = 0; i < 16; i++) begin
         drive(0, 0, 0, 0, 0, 1, 0);
         step();
      end
      check("tail_last", 64'(out_valid), 64'd0);

      // Backpressure: three pops across an alternating ready pattern
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 5'd4, 32'h700 + 32'(4 * i), 32'(i), 0, 0);
         step();
      end
      check("bp_occ3", 64'(occupancy), 64'd3);
      for (int i = 0; i < 5; i++) begin
         saved_pc = out_pc;
         drive(0, 0, 0, 0, 0, rdy_seq[i] != 0, 0);
         step();
         check("bp_occ", 64'(occupancy), 64'(occ_seq[i]));
         if (rdy_seq[i] == 0) check("bp_stable", 64'(out_pc), 64'(saved_pc));
      end

      // Asynchronous reset mid-stream
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1, 1, 5'd6, 32'h800 + 32'(4 * i), 32'(i), 0, 0);
         step();
      end
      check("mid_occ5", 64'(occupancy), 64'd5);
      #2 reset_n = 1'b0;
      #1;
      check("mid_valid", 64'(out_valid), 64'd0);
      check("mid_occ", 64'(occupancy), 64'd0);
      do_reset();
      check_model();

      // Random traffic
      for (int i = 0; i < 800; i++) begin
         logic [4:0] a;
         a = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         drive(($urandom % 10) != 0, ($urandom % 10) < 7, a, $urandom, $urandom,
               ($urandom % 10) < ((i / 200) % 2 == 0 ? 3 : 8), ($urandom % 40) == 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/wb_trace_fifo.md
Name: wb_trace_fifo

Overview:
- Commit-trace buffer directly downstream of the CPU core.
- Consumes the core's writeback debug bus (debug_wb_pc / _rf_wen / _rf_addr / _rf_wdata) every cycle.
- Filters register-file writes into commit records and queues them in a FIFO.
- Drains records over a valid/ready stream to a trace sink (UART dumper, bench scoreboard) and keeps commit/drop statistics.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 2.
SKIP_R0, 1, when 1, writes to register 0 are not captured.

Ports:
clk  input  1  system clock, 100 MHz; all state on rising edge.
reset_n  input  1  asynchronous active-low reset.
trace_en  input  1  capture enable; 0 ignores the debug bus (counters frozen).
clr_stats  input  1  synchronous one-cycle clear of commit_cnt, drop_cnt, overflow.
debug_wb_pc  input  32  PC of the instruction in WB.
debug_wb_rf_wen  input  1  WB register-file write enable.
debug_wb_rf_addr  input  5  WB destination register.
debug_wb_rf_wdata  input  32  WB write data.
out_valid  output  1  head record available.
out_ready  input  1  sink accepts head record.
out_pc  output  32  head record PC.
out_addr  output  5  head record destination register.
out_data  output  32  head record write data.
occupancy  output  $clog2(DEPTH)+1  entries currently stored.
commit_cnt  output  32  captured-commit count; wraps 0xFFFFFFFF -> 0.
drop_cnt  output  16  records lost to full FIFO; saturates at 0xFFFF.
overflow  output  1  sticky; set on first drop.

Behaviour:
- Reset (async assert, sync release): out_valid=0; occupancy=0; commit_cnt=0; drop_cnt=0; overflow=0.
  - Read/write pointers = 0; out_pc/out_addr/out_data = 0.
  - Reset mid-stream discards all stored records.
- Capture condition (cap): trace_en & debug_wb_rf_wen & !(SKIP_R0 & debug_wb_rf_addr==0).
  - Evaluated every cycle; the bus is sampled, never combinationally passed through.
- Each cap cycle is one commit. Consecutive cap cycles with identical PC are captured separately; no dedup.
- commit_cnt increments on every cap cycle, including dropped ones.
- Pop: out_valid & out_ready. Head advances at the next edge.
- Push: cap & (occupancy<DEPTH | pop).
  - A simultaneous pop frees a slot, so push is accepted when full + pop.
- Drop: cap & occupancy==DEPTH & !pop.
  - drop_cnt +1 (saturating at 0xFFFF).
  - overflow <= 1.
  - FIFO contents unchanged; the newest record is the one discarded.
- occupancy: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: record captured at edge N is visible on out_* with out_valid=1 after edge N when the FIFO was empty (one-cycle capture-to-output).
- Output stream:
  - out_* show the head entry (first-word-fall-through).
  - out_valid = occupancy!=0.
  - out_* stay stable while out_valid & !out_ready.
  - Records leave in capture order.
- Pointers: log2(DEPTH) bits, natural wrap; full/empty are derived from occupancy.
- clr_stats:
  - Zeroes commit_cnt, drop_cnt, overflow at the next edge.
  - Takes priority over any same-cycle increment: result is 0, not 1.
  - FIFO contents are untouched.
- trace_en=0: no captures, no counter changes; draining continues normally.
- out_ready with out_valid=0 has no effect.

Test Plan:
- Reset, then wen=1 addr=5 data=0x1234 pc=0x00400000 for one cycle, out_ready=0 -> next cycle out_valid=1, out_pc=0x00400000, out_addr=5, out_data=0x1234, occupancy=1, commit_cnt=1.
- SKIP_R0=1, wen=1 addr=0 for 3 cycles -> occupancy=0, commit_cnt=0, out_valid=0.
- DEPTH=16, out_ready=0, 20 consecutive captures with pc=0x100+4i:
  - occupancy=16, drop_cnt=4, overflow=1, commit_cnt=20.
  - Draining yields pc 0x100..0x13C in order.
- FIFO full, out_ready=1 while cap=1 -> occupancy stays 16, drop_cnt unchanged, new record appears last.
- Backpressure: 3 records queued, toggle out_ready 1,0,1,0,1 -> exactly 3 pops; out_* stable during ready=0; occupancy 3,2,2,1,1,0.
- clr_stats asserted in the same cycle as a drop -> drop_cnt=0 and overflow=0 next cycle.
- Assert reset_n=0 mid-stream with occupancy=5 -> immediately out_valid=0, occupancy=0.
